pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_pkg.sv | 19 +
 rtl/pipe_hazard_timer.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (package). Backpressure: n/a.
// Holds the FSM state enum, the load/store opcodes and a memory-op decode helper.
package pipe_hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_BR_FLUSH = 2'd2
  } state_e;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  function automatic logic is_memop(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/pipe_hazard_timer.sv
// Wait-cycle counter for one stalled data-memory access.
// Latency: timeout is combinational from the registered count.
// Backpressure: none; clr has priority over en.
// Ports: clk, rst (sync, active-high), clr, en, timeout (count == MEM_TIMEOUT-1).
module pipe_hazard_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int W = $clog2(MEM_TIMEOUT);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign timeout = (cnt_q == LAST);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-access stalls with timeout, branch flush, perf counters.
// Latency: stall/flush/dmem_req/mem_err are combinational in the cycle they apply; state is registered.
// Backpressure: dmem_ack low stalls the whole pipe for at most MEM_TIMEOUT cycles per access.
// Ports: clk, rst (sync, active-high); inst_e, inst_w, br_taken_e, dmem_ack in;
//        dmem_req, stall_f/e/w, flush_e, mem_err, state_o, stall_cnt, flush_cnt out.
// Build option: define PIPE_HAZARD_PERF_EN to build the saturating perf counters;
//               otherwise stall_cnt/flush_cnt are tied to zero.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_e,
  input  logic [31:0]      inst_w,
  input  logic             br_taken_e,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             stall_f,
  output logic             stall_e,
  output logic             stall_w,
  output logic             flush_e,
  output logic             mem_err,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [1:0] state_q, state_d;
  logic       memop_w;
  logic       stall, flush, req, err;
  logic       tmr_clr, tmr_en, tmr_to;

  // inst_e only travels with the branch outcome; no field of it is decoded here.
  logic unused_inst;
  assign unused_inst = ^{inst_e, inst_w[31:7]};

  assign memop_w = is_memop(inst_w[6:0]);

  always_comb begin
    state_d = ST_RUN;
    stall   = 1'b0;
    flush   = 1'b0;
    req     = 1'b0;
    err     = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      ST_RUN: begin
        req     = memop_w;
        tmr_clr = 1'b1;
        if (memop_w && !dmem_ack) begin
          stall   = 1'b1;
          state_d = ST_MEM_WAIT;
        end else if (br_taken_e) begin
          flush   = 1'b1;
          state_d = ST_BR_FLUSH;
        end
      end
      ST_MEM_WAIT: begin
        req = memop_w;
        if (!dmem_ack && !tmr_to) begin
          stall   = 1'b1;
          tmr_en  = 1'b1;
          state_d = ST_MEM_WAIT;
        end else begin
          // Access ends (ack or timeout); a branch held in E during the
          // stall is resolved in this releasing cycle.
          err = !dmem_ack;
          if (br_taken_e) begin
            flush   = 1'b1;
            state_d = ST_BR_FLUSH;
          end
        end
      end
      ST_BR_FLUSH: begin
        // Kills the instruction fetched from the wrong path; W memops ignored.
        flush = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (rst) begin
      state_d = ST_RUN;
      stall   = 1'b0;
      flush   = 1'b1;
      req     = 1'b0;
      err     = 1'b0;
      tmr_clr = 1'b1;
      tmr_en  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_hazard_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .timeout (tmr_to)
  );

  assign dmem_req = req;
  assign stall_f  = stall;
  assign stall_e  = stall;
  assign stall_w  = stall;
  assign flush_e  = flush;
  assign mem_err  = err;
  assign state_o  = rst ? ST_RUN : state_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Zero while reset is held, not just from the first reset edge onward.
  assign stall_cnt = rst ? '0 : stall_cnt_q;
  assign flush_cnt = rst ? '0 : flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int MT  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;
`ifdef PIPE_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] LOAD  = 32'h0000_2003;
  localparam logic [31:0] STORE = 32'h0000_2023;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [31:0]   inst_e = '0, inst_w = '0;
  logic          br_taken_e = 1'b0, dmem_ack = 1'b0;
  logic          dmem_req, stall_f, stall_e, stall_w, flush_e, mem_err;
  logic [1:0]    state_o;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .inst_e(inst_e), .inst_w(inst_w),
    .br_taken_e(br_taken_e), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .stall_f(stall_f), .stall_e(stall_e), .stall_w(stall_w),
    .flush_e(flush_e), .mem_err(mem_err), .state_o(state_o),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: cycles already stalled for the open access, whether a
  // post-branch flush cycle is owed, and the two event tallies.
  int m_stalled = 0, m_sc = 0, m_fc = 0;
  bit m_pend = 0;
  int n_stalled = 0, n_sc = 0, n_fc = 0;
  bit n_pend = 0;

  logic [7:0]    exp_vec, obs_vec;
  logic [CW-1:0] exp_sc, exp_fc;
  logic          last_stall = 1'b0;

  task automatic cycle(input logic [31:0] iw, input logic b, input logic a, input logic r);
    logic e_req, e_st, e_fl, e_err, memop;
    logic [1:0] e_state;
    m_stalled = n_stalled; m_pend = n_pend; m_sc = n_sc; m_fc = n_fc;
    @(negedge clk);
    rst = r; inst_w = iw; inst_e = $urandom; br_taken_e = b; dmem_ack = a;
    #1;
    memop = (iw[6:0] == 7'b0000011) || (iw[6:0] == 7'b0100011);
    e_req = 0; e_st = 0; e_fl = 0; e_err = 0; e_state = 2'd0;
    n_stalled = m_stalled; n_pend = 0; n_sc = m_sc; n_fc = m_fc;
    if (r) begin
      e_fl = 1; n_stalled = 0; n_sc = 0; n_fc = 0;
    end else begin
      e_state = m_pend ? 2'd2 : (m_stalled > 0 ? 2'd1 : 2'd0);
      if (m_pend) begin
        e_fl = 1;
      end else begin
        if (memop) begin
          e_req = 1;
          if (a) n_stalled = 0;
          else if (m_stalled == MT) begin e_err = 1; n_stalled = 0; end
          else begin e_st = 1; n_stalled = m_stalled + 1; end
        end
        if (b && !e_st) begin e_fl = 1; n_pend = 1; end
      end
      if (e_st && n_sc < SAT) n_sc = n_sc + 1;
      if (e_fl && n_fc < SAT) n_fc = n_fc + 1;
    end
    exp_vec = {e_req, e_st, e_st, e_st, e_fl, e_err, e_state};
    exp_sc  = (PERF && !r) ? CW'(m_sc) : '0;
    exp_fc  = (PERF && !r) ? CW'(m_fc) : '0;
    obs_vec = {dmem_req, stall_f, stall_e, stall_w, flush_e, mem_err, state_o};
    last_stall = e_st;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(LOAD, 1'b1, 1'b0, 1'b1);
      checks++;
      if (obs_vec !== 8'b0000_1000) begin
        errors++; $display("FAIL reset_outputs k=%0d got %b want %b", k, obs_vec, 8'b0000_1000);
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== '0) begin
        errors++; $display("FAIL reset_counters k=%0d got %h/%h want 0/0", k, stall_cnt, flush_cnt);
      end
    end
  endtask

  task automatic test_timeout();
    cycle(NOP, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cycle((k < 5) ? LOAD : NOP, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL timeout_model k=%0d got %b want %b", k, obs_vec, exp_vec);
      end
      checks++;
      if ((k < 4 && stall_f !== 1'b1) || (k == 4 && {mem_err, stall_f} !== 2'b10) ||
          (k == 5 && {mem_err, state_o} !== 3'b000)) begin
        errors++; $display("FAIL timeout_seq k=%0d got stall=%b err=%b st=%0d", k, stall_f, mem_err, state_o);
      end
    end
    checks++;
    if (stall_cnt !== (PERF ? CW'(4) : CW'(0))) begin
      errors++; $display("FAIL timeout_stall_cnt got %0d want %0d", stall_cnt, PERF ? 4 : 0);
    end
  endtask

  task automatic test_store_ack();
    cycle(NOP, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle((k <= 2) ? STORE : NOP, 1'b0, (k == 2), 1'b0);
      checks++;
      if (obs_vec !== exp_vec || dmem_req !== (k <= 2) || stall_f !== (k < 2)) begin
        errors++; $display("FAIL store_ack k=%0d got %b want %b", k, obs_vec, exp_vec);
      end
    end
    checks++;
    if (stall_cnt !== (PERF ? CW'(2) : CW'(0))) begin
      errors++; $display("FAIL store_stall_cnt got %0d want %0d", stall_cnt, PERF ? 2 : 0);
    end
  endtask

  task automatic test_branch();
    cycle(NOP, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      // br stays high in BR_FLUSH to show it is ignored there
      cycle(NOP, (k <= 1), 1'b0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec || flush_e !== (k <= 1)) begin
        errors++; $display("FAIL branch k=%0d got %b want %b", k, obs_vec, exp_vec);
      end
    end
    checks++;
    if (flush_cnt !== (PERF ? CW'(2) : CW'(0)) || state_o !== 2'd0) begin
      errors++; $display("FAIL branch_cnt got %0d st=%0d want %0d st=0", flush_cnt, state_o, PERF ? 2 : 0);
    end
  endtask

  task automatic test_stall_branch();
    cycle(NOP, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle((k <= 3) ? LOAD : NOP, (k <= 3), (k == 3), 1'b0);
      checks++;
      if (obs_vec !== exp_vec || flush_e !== (k >= 3) || stall_f !== (k < 3)) begin
        errors++; $display("FAIL stall_branch k=%0d got %b want %b", k, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    cycle(NOP, 1'b0, 1'b0, 1'b1);
    cycle(LOAD, 1'b0, 1'b0, 1'b0);
    cycle(LOAD, 1'b0, 1'b0, 1'b0);
    checks++;
    if (state_o !== 2'd1 || stall_f !== 1'b1) begin
      errors++; $display("FAIL midwait_enter got st=%0d stall=%b want 1/1", state_o, stall_f);
    end
    cycle(LOAD, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_vec !== 8'b0000_1000 || {stall_cnt, flush_cnt} !== '0) begin
      errors++; $display("FAIL midwait_reset got %b cnt %0d/%0d want 00001000 0/0", obs_vec, stall_cnt, flush_cnt);
    end
    cycle(NOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_vec !== exp_vec || state_o !== 2'd0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL midwait_after got %b want %b", obs_vec, exp_vec);
    end
  endtask

  task automatic test_random();
    logic [31:0] iw;
    logic b, a, r;
    iw = NOP; b = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!last_stall) begin
        iw = $urandom;
        case ($urandom_range(0, 3))
          0: iw[6:0] = 7'b0000011;
          1: iw[6:0] = 7'b0100011;
          default: iw[6:0] = 7'b0110011;
        endcase
        b = ($urandom_range(0, 3) == 0);
      end
      a = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 63) == 0);
      cycle(iw, b, a, r);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL random_outputs k=%0d got %b want %b", k, obs_vec, exp_vec);
      end
      checks++;
      if (stall_cnt !== exp_sc || flush_cnt !== exp_fc) begin
        errors++; $display("FAIL random_counters k=%0d got %0d/%0d want %0d/%0d",
                           k, stall_cnt, flush_cnt, exp_sc, exp_fc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_store_ack();
    test_branch();
    test_stall_branch();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
